// File: rtl/stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// stream_demux_1xn
//   Registered 1-to-NUM_CH stream demultiplexer. Each accepted input beat is
//   written into the one-entry output register of the channel chosen by in_sel,
//   or into every channel at once when in_bcast is set. Beats whose select is
//   outside 0..NUM_CH-1 are consumed, discarded and counted in drop_cnt.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat may be accepted this cycle
//   in_data    input payload (DATA_W)
//   in_sel     destination channel index (SEL_W)
//   in_bcast   1 = write the beat to every channel, in_sel ignored
//   out_valid  per-channel valid, bit i = channel i (NUM_CH)
//   out_ready  per-channel ready (NUM_CH)
//   out_data   channel i payload at [i*DATA_W +: DATA_W]
//   drop_cnt   saturating count of dropped out-of-range beats (CNT_W)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. A producer holding valid=1 keeps its payload stable until that edge.
// in_ready depends only on out_ready, registered state, in_sel and in_bcast,
// never on in_valid, so there is no combinational in_valid -> out_valid path.
//
// SEL_W must be >= $clog2(NUM_CH).
// -----------------------------------------------------------------------------
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_bcast,
  output logic [NUM_CH-1:0]          out_valid,
  input  logic [NUM_CH-1:0]          out_ready,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]           drop_cnt
);

  // One extra bit so NUM_CH == 2**SEL_W is still representable.
  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] valid_q;
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic              sel_ok;
  logic              sel_free;
  logic              accept;
  logic              drop;

  always_comb begin
    // A channel can take a beat if it is empty or is being drained this edge.
    free     = ~valid_q | out_ready;
    sel_ok   = ({1'b0, in_sel} < NUM_CH_V);
    sel_free = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_sel == SEL_W'(i)) sel_free = free[i];
    end

    // Broadcast waits for every channel so it is all-or-nothing.
    // Out-of-range selects are always ready: the beat is consumed and dropped.
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;

    accept = in_valid & in_ready;
    drop   = accept & ~in_bcast & ~sel_ok;

    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(i))));
    end
  end

  // Load has priority over drain, so drain+load on one edge replaces the beat
  // and keeps valid high: one beat per cycle per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i])           valid_q[i] <= 1'b1;
        else if (out_ready[i]) valid_q[i] <= 1'b0;
      end
    end
  end

  // Payload is only written on load; it keeps its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign out_valid = valid_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1xn
//   Directed bench for stream_demux_1xn. Instance a: 16 channels, 16-bit drop
//   counter. Instance b: 12 channels, SEL_W=4, 2-bit drop counter, used for the
//   out-of-range select and saturation cases.
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   (or #1 after an input change for the combinational in_ready).
// -----------------------------------------------------------------------------
module tb_stream_demux_1xn;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a (16 ch) ----------------
  logic          a_in_valid;
  logic          a_in_ready;
  logic [7:0]    a_in_data;
  logic [3:0]    a_in_sel;
  logic          a_in_bcast;
  logic [15:0]   a_out_valid;
  logic [15:0]   a_out_ready;
  logic [127:0]  a_out_data;
  logic [15:0]   a_drop_cnt;

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(16), .SEL_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .drop_cnt(a_drop_cnt)
  );

  // ---------------- instance b (12 ch, 2-bit counter) ----------------
  logic          b_in_valid;
  logic          b_in_ready;
  logic [7:0]    b_in_data;
  logic [3:0]    b_in_sel;
  logic          b_in_bcast;
  logic [11:0]   b_out_valid;
  logic [11:0]   b_out_ready;
  logic [95:0]   b_out_data;
  logic [1:0]    b_drop_cnt;

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(12), .SEL_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt)
  );

  int n_checks;
  int n_fail;

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input logic [3:0] sel, input logic [7:0] d,
                         input logic bc);
    a_in_valid = v;
    a_in_sel   = sel;
    a_in_data  = d;
    a_in_bcast = bc;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] sel, input logic [7:0] d);
    b_in_valid = v;
    b_in_sel   = sel;
    b_in_data  = d;
    b_in_bcast = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive_a(1'b0, 4'd0, 8'h00, 1'b0);
    drive_b(1'b0, 4'd0, 8'h00);
    a_out_ready = '1;
    b_out_ready = '1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0000) begin
      n_fail++; $display("FAIL reset_a_valid got=%h exp=%h", a_out_valid, 16'h0000);
    end
    n_checks++;
    if (a_out_data !== 128'h0) begin
      n_fail++; $display("FAIL reset_a_data got=%h exp=0", a_out_data);
    end
    n_checks++;
    if (a_drop_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL reset_a_drop got=%0d exp=0", a_drop_cnt);
    end
    n_checks++;
    if (b_out_valid !== 12'h000 || b_drop_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_b got valid=%h drop=%0d exp valid=0 drop=0",
                         b_out_valid, b_drop_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    a_out_ready = '1;
    drive_a(1'b1, 4'd5, 8'hA5, 1'b0);
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_in_ready got=%b exp=1", a_in_ready);
    end
    @(negedge clk);
    drive_a(1'b0, 4'd0, 8'h00, 1'b0);
    n_checks++;
    if (a_out_valid !== 16'h0020) begin
      n_fail++; $display("FAIL single_valid got=%h exp=0020", a_out_valid);
    end
    n_checks++;
    if (a_out_data[5*8 +: 8] !== 8'hA5) begin
      n_fail++; $display("FAIL single_data got=%h exp=a5", a_out_data[5*8 +: 8]);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0000) begin
      n_fail++; $display("FAIL single_drain got=%h exp=0000", a_out_valid);
    end
    n_checks++;
    if (a_out_data[5*8 +: 8] !== 8'hA5) begin
      n_fail++; $display("FAIL single_hold_after_drain got=%h exp=a5", a_out_data[5*8 +: 8]);
    end
  endtask

  task automatic test_stall;
    a_out_ready = 16'hFFF7;
    drive_a(1'b1, 4'd3, 8'h11, 1'b0);
    @(negedge clk);
    drive_a(1'b1, 4'd3, 8'h22, 1'b0);
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready got=%b exp=0", a_in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0008 || a_out_data[3*8 +: 8] !== 8'h11) begin
      n_fail++; $display("FAIL stall_hold got valid=%h data=%h exp valid=0008 data=11",
                         a_out_valid, a_out_data[3*8 +: 8]);
    end
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready2 got=%b exp=0", a_in_ready);
    end
    a_out_ready = '1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready got=%b exp=1", a_in_ready);
    end
    @(negedge clk);
    drive_a(1'b0, 4'd0, 8'h00, 1'b0);
    n_checks++;
    if (a_out_valid !== 16'h0008 || a_out_data[3*8 +: 8] !== 8'h22) begin
      n_fail++; $display("FAIL stall_replace got valid=%h data=%h exp valid=0008 data=22",
                         a_out_valid, a_out_data[3*8 +: 8]);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0000) begin
      n_fail++; $display("FAIL stall_drain got=%h exp=0000", a_out_valid);
    end
  endtask

  task automatic test_bcast;
    logic [127:0] exp_all;
    exp_all = {16{8'h5C}};
    a_out_ready = 16'hFF7F;
    drive_a(1'b1, 4'd7, 8'h77, 1'b0);
    @(negedge clk);
    drive_a(1'b1, 4'd9, 8'h5C, 1'b1);
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bcast_blocked_ready got=%b exp=0", a_in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0080 || a_out_data[7*8 +: 8] !== 8'h77 ||
        a_out_data[0 +: 8] !== 8'h00) begin
      n_fail++; $display("FAIL bcast_no_partial got valid=%h d7=%h d0=%h exp 0080/77/00",
                         a_out_valid, a_out_data[7*8 +: 8], a_out_data[0 +: 8]);
    end
    a_out_ready = '1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bcast_release_ready got=%b exp=1", a_in_ready);
    end
    @(negedge clk);
    drive_a(1'b0, 4'd0, 8'h00, 1'b0);
    n_checks++;
    if (a_out_valid !== 16'hFFFF) begin
      n_fail++; $display("FAIL bcast_valid got=%h exp=ffff", a_out_valid);
    end
    n_checks++;
    if (a_out_data !== exp_all) begin
      n_fail++; $display("FAIL bcast_data got=%h exp=%h", a_out_data, exp_all);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 16'h0000) begin
      n_fail++; $display("FAIL bcast_drain got=%h exp=0000", a_out_valid);
    end
  endtask

  task automatic test_drop;
    logic [3:0] drop_sel [5];
    logic [1:0] exp_cnt  [5];
    drop_sel = '{4'd13, 4'd12, 4'd15, 4'd14, 4'd13};
    exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    // Park a stalled beat in ch1 so "unchanged" is visible.
    b_out_ready = 12'hFFD;
    drive_b(1'b1, 4'd1, 8'hB1);
    @(negedge clk);
    // Highest in-range select loads normally.
    drive_b(1'b1, 4'd11, 8'hBB);
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 12'h802 || b_drop_cnt !== 2'd0) begin
      n_fail++; $display("FAIL drop_inrange got valid=%h drop=%0d exp 802/0",
                         b_out_valid, b_drop_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      drive_b(1'b1, drop_sel[k], 8'hE0 + 8'(k));
      #1;
      n_checks++;
      if (b_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL drop_ready[%0d] got=%b exp=1", k, b_in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (b_drop_cnt !== exp_cnt[k]) begin
        n_fail++; $display("FAIL drop_cnt[%0d] got=%0d exp=%0d", k, b_drop_cnt, exp_cnt[k]);
      end
      n_checks++;
      if (b_out_valid !== 12'h002 || b_out_data[1*8 +: 8] !== 8'hB1 ||
          b_out_data[11*8 +: 8] !== 8'hBB) begin
        n_fail++; $display("FAIL drop_unchanged[%0d] got valid=%h d1=%h d11=%h exp 002/b1/bb",
                           k, b_out_valid, b_out_data[1*8 +: 8], b_out_data[11*8 +: 8]);
      end
    end
    drive_b(1'b0, 4'd0, 8'h00);
    b_out_ready = '1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q15[$];
    logic [7:0] exp_v;
    a_out_ready = '1;
    for (int k = 0; k <= 32; k++) begin
      // Observe the beat accepted on the previous edge.
      if (k > 0) begin
        n_checks++;
        if (a_out_valid !== (((k - 1) % 2 == 0) ? 16'h0001 : 16'h8000)) begin
          n_fail++; $display("FAIL b2b_valid[%0d] got=%h", k, a_out_valid);
        end
      end
      if (a_out_valid[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) begin
          n_fail++; $display("FAIL b2b_ch0_extra got=%h exp=none", a_out_data[0 +: 8]);
        end else begin
          exp_v = exp_q0.pop_front();
          if (a_out_data[0 +: 8] !== exp_v) begin
            n_fail++; $display("FAIL b2b_ch0 got=%h exp=%h", a_out_data[0 +: 8], exp_v);
          end
        end
      end
      if (a_out_valid[15]) begin
        n_checks++;
        if (exp_q15.size() == 0) begin
          n_fail++; $display("FAIL b2b_ch15_extra got=%h exp=none", a_out_data[15*8 +: 8]);
        end else begin
          exp_v = exp_q15.pop_front();
          if (a_out_data[15*8 +: 8] !== exp_v) begin
            n_fail++; $display("FAIL b2b_ch15 got=%h exp=%h", a_out_data[15*8 +: 8], exp_v);
          end
        end
      end
      if (k < 32) begin
        drive_a(1'b1, (k % 2 == 0) ? 4'd0 : 4'd15, 8'(k + 1), 1'b0);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, a_in_ready);
        end
        if (k % 2 == 0) exp_q0.push_back(8'(k + 1));
        else            exp_q15.push_back(8'(k + 1));
      end else begin
        drive_a(1'b0, 4'd0, 8'h00, 1'b0);
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q0.size() != 0 || exp_q15.size() != 0 || a_out_valid !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_leftover got q0=%0d q15=%0d valid=%h exp 0/0/0000",
                         exp_q0.size(), exp_q15.size(), a_out_valid);
    end
    n_checks++;
    if (a_drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL a_no_drops got=%0d exp=0", a_drop_cnt);
    end
  endtask

  task automatic test_async_reset;
    a_out_ready = 16'hFFFB;
    drive_a(1'b1, 4'd2, 8'h2A, 1'b0);
    @(negedge clk);
    drive_a(1'b0, 4'd0, 8'h00, 1'b0);
    n_checks++;
    if (a_out_valid !== 16'h0004 || a_out_data[2*8 +: 8] !== 8'h2A) begin
      n_fail++; $display("FAIL areset_pre got valid=%h d2=%h exp 0004/2a",
                         a_out_valid, a_out_data[2*8 +: 8]);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 16'h0000 || a_out_data !== 128'h0) begin
      n_fail++; $display("FAIL areset_immediate got valid=%h data=%h exp 0/0",
                         a_out_valid, a_out_data);
    end
    n_checks++;
    if (b_drop_cnt !== 2'd0 || b_out_valid !== 12'h000) begin
      n_fail++; $display("FAIL areset_b got drop=%0d valid=%h exp 0/000", b_drop_cnt, b_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = '0;
    for (int s = 0; s < 16; s++) begin
      drive_a(1'b0, 4'(s), 8'h00, 1'b0);
      #1;
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL areset_ready[sel=%0d] got=%b exp=1", s, a_in_ready);
      end
    end
    a_out_ready = '1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_stall();
    test_bcast();
    test_drop();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
